// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, imem request/response, IR and redirects
// Optional misaligned-target trap enabled by defining MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        ex_valid,
    input  logic [1:0]  ex_branch,
    input  logic        ex_cond,
    input  logic [31:0] ex_pc_target,
    input  logic [31:0] ex_alu_result,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3
`ifdef MISALIGN_TRAP_EN
        , FAULT = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        taken;
    logic        redirect;
    logic [31:0] target;
    logic        unused_bits;

    assign taken  = ex_valid & (((ex_branch == 2'b01) & ex_cond) | ex_branch[1]);
    assign target = (ex_branch == 2'b11) ? {ex_alu_result[31:1], 1'b0} : ex_pc_target;
    assign unused_bits = ^{ex_alu_result[0], target[1:0]};

`ifdef MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    // Once faulted, further redirects are ignored until reset.
    assign redirect    = taken & (state_q != FAULT);
    assign fetch_fault = fault_q;
`else
    assign redirect    = taken;
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
`ifdef MISALIGN_TRAP_EN
        fault_d  = fault_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: begin
                if (imem_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
`ifdef MISALIGN_TRAP_EN
            FAULT: valid_d = 1'b0;
`endif
            default: state_d = IDLE;
        endcase

        // Redirect overrides stall, sequential advance and any word arriving this cycle.
        if (redirect) begin
            valid_d  = 1'b0;
            instr_d  = instr_q;
            pc_out_d = pc_out_q;
            pc_d     = {target[31:2], 2'b00};
            case (state_q)
                IDLE, HOLD: state_d = REQ;
                REQ: begin
                    kill_d  = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    kill_d  = ~imem_valid;
                    state_d = imem_valid ? REQ : WAIT;
                end
                default: state_d = state_q;
            endcase
`ifdef MISALIGN_TRAP_EN
            if (target[1:0] != 2'b00) begin
                pc_d    = pc_q;
                kill_d  = 1'b0;
                fault_d = 1'b1;
                state_d = FAULT;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
`ifdef MISALIGN_TRAP_EN
            fault_q  <= fault_d;
`endif
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit (honours MISALIGN_TRAP_EN)
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        ex_valid;
    logic [1:0]  ex_branch;
    logic        ex_cond;
    logic [31:0] ex_pc_target;
    logic [31:0] ex_alu_result;
    logic        stall;
    logic [31:0] instr;
    logic [6:0]  op;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int lat       = 1;
    int cnt       = 0;
    logic [31:0] req_addr = 32'h0;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_cond(ex_cond),
        .ex_pc_target(ex_pc_target), .ex_alu_result(ex_alu_result),
        .stall(stall), .instr(instr), .op(op), .instr_valid(instr_valid),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {a[19:0], 12'h013};
    endfunction

    // Instruction memory: response lat cycles after the request cycle.
    always @(negedge clk) begin
        if (cnt == 1) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(req_addr);
            cnt = 0;
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (cnt > 1) cnt = cnt - 1;
        end
        if (imem_req === 1'b1) begin
            cnt = lat;
            req_addr = imem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic clear_ex();
        ex_valid = 1'b0; ex_branch = 2'b00; ex_cond = 1'b0;
        ex_pc_target = 32'h0; ex_alu_result = 32'h0;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr, instr_valid, pc_out, imem_req, fetch_fault, op, pc_plus4} !==
            {32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0, 7'h13, 32'h4})
            $display("FAIL reset_state: instr=%h v=%b pc=%h req=%b fault=%b op=%h p4=%h required 00000013 0 00000000 0 0 13 00000004",
                     instr, instr_valid, pc_out, imem_req, fetch_fault, op, pc_plus4);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_seq();
        bit got;
        @(negedge clk);
        wait_req(got);
        total_cnt++;
        if ({got, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL seq_req0: got=%b addr=%h required 1 00000000", got, imem_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0})
            $display("FAIL seq_wait0: req=%b addr=%h required 0 00000000", imem_req, imem_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({instr_valid, instr, pc_out, op, pc_plus4} !== {1'b1, 32'h0050_0093, 32'h0, 7'h13, 32'h4})
            $display("FAIL seq_instr0: v=%b instr=%h pc=%h op=%h p4=%h required 1 00500093 00000000 13 00000004",
                     instr_valid, instr, pc_out, op, pc_plus4);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0})
            $display("FAIL seq_req4: req=%b addr=%h v=%b required 1 00000004 0", imem_req, imem_addr, instr_valid);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr_valid, instr, pc_out, op} !== {1'b1, 32'h0010_0113, 32'h4, 7'h13})
            $display("FAIL seq_instr4: v=%b instr=%h pc=%h op=%h required 1 00100113 00000004 13",
                     instr_valid, instr, pc_out, op);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({instr_valid, instr, pc_out, imem_req} !== {1'b1, 32'h0010_0113, 32'h4, 1'b0})
                $display("FAIL stall_hold%0d: v=%b instr=%h pc=%h req=%b required 1 00100113 00000004 0",
                         i, instr_valid, instr, pc_out, imem_req);
            else pass_cnt++;
        end
        stall = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8})
            $display("FAIL stall_release: req=%b addr=%h required 1 00000008", imem_req, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_redirect_wait();
        bit got;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr_valid, pc_out, instr} !== {1'b1, 32'h8, 32'h0000_8013})
            $display("FAIL rw_instr8: v=%b pc=%h instr=%h required 1 00000008 00008013", instr_valid, pc_out, instr);
        else pass_cnt++;
        lat = 3;
        @(negedge clk);
        @(negedge clk);
        ex_valid = 1'b1; ex_branch = 2'b10; ex_pc_target = 32'h100;
        @(negedge clk);
        clear_ex();
        total_cnt++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b0, 32'h100})
            $display("FAIL rw_killed: v=%b req=%b addr=%h required 0 0 00000100", instr_valid, imem_req, imem_addr);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL rw_refetch: req=%b addr=%h v=%b required 1 00000100 0", imem_req, imem_addr, instr_valid);
        else pass_cnt++;
        wait_valid(got);
        total_cnt++;
        if ({got, instr, pc_out} !== {1'b1, 32'h0010_0013, 32'h100})
            $display("FAIL rw_target_word: got=%b instr=%h pc=%h required 1 00100013 00000100", got, instr, pc_out);
        else pass_cnt++;
    endtask

    task automatic test_cond_branch();
        stall = 1'b1;
        lat = 1;
        ex_valid = 1'b1; ex_branch = 2'b01; ex_cond = 1'b0; ex_pc_target = 32'h40;
        @(negedge clk);
        total_cnt++;
        if ({instr_valid, pc_out, imem_req} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL cond_not_taken: v=%b pc=%h req=%b required 1 00000100 0", instr_valid, pc_out, imem_req);
        else pass_cnt++;
        ex_cond = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h40, 1'b0})
            $display("FAIL cond_taken: req=%b addr=%h v=%b required 1 00000040 0", imem_req, imem_addr, instr_valid);
        else pass_cnt++;
        clear_ex();
        stall = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr_valid, instr, pc_out} !== {1'b1, 32'h0004_0013, 32'h40})
            $display("FAIL cond_word: v=%b instr=%h pc=%h required 1 00040013 00000040", instr_valid, instr, pc_out);
        else pass_cnt++;
        stall = 1'b1;
    endtask

    task automatic test_jalr();
        ex_valid = 1'b1; ex_branch = 2'b11; ex_alu_result = 32'h205; ex_pc_target = 32'h999;
        @(negedge clk);
        total_cnt++;
        if ({imem_req, imem_addr, instr_valid, fetch_fault} !== {1'b1, 32'h204, 1'b0, 1'b0})
            $display("FAIL jalr_redirect: req=%b addr=%h v=%b fault=%b required 1 00000204 0 0",
                     imem_req, imem_addr, instr_valid, fetch_fault);
        else pass_cnt++;
        clear_ex();
        stall = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr_valid, instr, pc_out, pc_plus4} !== {1'b1, 32'h0020_4013, 32'h204, 32'h208})
            $display("FAIL jalr_word: v=%b instr=%h pc=%h p4=%h required 1 00204013 00000204 00000208",
                     instr_valid, instr, pc_out, pc_plus4);
        else pass_cnt++;
        stall = 1'b1;
    endtask

    task automatic test_wrap();
        ex_valid = 1'b1; ex_branch = 2'b10; ex_pc_target = 32'hFFFF_FFFC;
        @(negedge clk);
        clear_ex();
        stall = 1'b0;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC})
            $display("FAIL wrap_req: req=%b addr=%h required 1 fffffffc", imem_req, imem_addr);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr, pc_out, pc_plus4} !== {32'hFFFF_C013, 32'hFFFF_FFFC, 32'h0})
            $display("FAIL wrap_word: instr=%h pc=%h p4=%h required ffffc013 fffffffc 00000000", instr, pc_out, pc_plus4);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL wrap_next: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr_valid, instr, pc_out} !== {1'b1, 32'h0050_0093, 32'h0})
            $display("FAIL wrap_word0: v=%b instr=%h pc=%h required 1 00500093 00000000", instr_valid, instr, pc_out);
        else pass_cnt++;
        stall = 1'b1;
    endtask

    task automatic test_misalign();
        ex_valid = 1'b1; ex_branch = 2'b10; ex_pc_target = 32'h302;
        @(negedge clk);
        clear_ex();
`ifdef MISALIGN_TRAP_EN
        begin
            int n;
            total_cnt++;
            if ({fetch_fault, imem_req, instr_valid} !== {1'b1, 1'b0, 1'b0})
                $display("FAIL misalign_fault: fault=%b req=%b v=%b required 1 0 0", fetch_fault, imem_req, instr_valid);
            else pass_cnt++;
            n = 0;
            repeat (4) begin
                @(negedge clk);
                if (imem_req === 1'b1) n++;
            end
            total_cnt++;
            if (n != 0 || fetch_fault !== 1'b1)
                $display("FAIL misalign_sticky: reqs=%0d fault=%b required 0 1", n, fetch_fault);
            else pass_cnt++;
            stall = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            total_cnt++;
            if (fetch_fault !== 1'b0)
                $display("FAIL misalign_clear: fault=%b required 0", fetch_fault);
            else pass_cnt++;
        end
`else
        total_cnt++;
        if ({imem_req, imem_addr, fetch_fault} !== {1'b1, 32'h300, 1'b0})
            $display("FAIL misalign_forced: req=%b addr=%h fault=%b required 1 00000300 0", imem_req, imem_addr, fetch_fault);
        else pass_cnt++;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr_valid, pc_out, instr} !== {1'b1, 32'h300, 32'h0030_0013})
            $display("FAIL misalign_word: v=%b pc=%h instr=%h required 1 00000300 00300013", instr_valid, pc_out, instr);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        bit got;
        lat = 2;
        wait_req(got);
        total_cnt++;
        if (got !== 1'b1)
            $display("FAIL rm_req: got=%b required 1", got);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({instr_valid, instr, pc_out, imem_req} !== {1'b0, 32'h0000_0013, 32'h0, 1'b0})
            $display("FAIL rm_reset: v=%b instr=%h pc=%h req=%b required 0 00000013 00000000 0",
                     instr_valid, instr, pc_out, imem_req);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({imem_req, imem_addr, instr_valid, instr} !== {1'b1, 32'h0, 1'b0, 32'h0000_0013})
            $display("FAIL rm_restart: req=%b addr=%h v=%b instr=%h required 1 00000000 0 00000013",
                     imem_req, imem_addr, instr_valid, instr);
        else pass_cnt++;
        wait_valid(got);
        total_cnt++;
        if ({got, instr, pc_out} !== {1'b1, 32'h0050_0093, 32'h0})
            $display("FAIL rm_word: got=%b instr=%h pc=%h required 1 00500093 00000000", got, instr, pc_out);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        clear_ex();
        test_reset();
        test_seq();
        test_stall();
        test_redirect_wait();
        test_cond_branch();
        test_jalr();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
